// File: rtl/ysyx_22041412_fetch_buffer.sv
// Instruction fetch front end: owns the fetch PC, requests 16-byte lines from the
// instruction cache, keeps the last line in a one-line buffer and slices it into a
// 2-entry decode queue. Define FETCH_PERF_EN to build the line-hit/stall counters.
module ysyx_22041412_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         ic_valid,
    output logic [31:0]  ic_addr,
    input  logic [127:0] ic_data,
    input  logic         ic_ready,
    output logic         ic_read_valid,
    output logic         ic_read_clean,
    output logic         dec_valid,
    output logic [31:0]  dec_pc,
    output logic [31:0]  dec_inst,
    input  logic         dec_ready,
    output logic [63:0]  perf_lb_hit,
    output logic [63:0]  perf_stall
);
    localparam int unsigned QDEPTH = 2;

    typedef enum logic [1:0] {IDLE, REQ, ACK, SERVE} state_t;

    state_t        state, state_n;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic          kill, kill_n;
    logic          lb_valid;
    logic [27:0]   lb_tag;
    logic [127:0]  lb_data;
    logic [31:0]   q_pc   [QDEPTH];
    logic [31:0]   q_inst [QDEPTH];
    logic [1:0]    q_count;

    logic          lb_load_c, push_c, pop_c, flush_c, q_full_c, redir_hit_c;
    logic [31:0]   redir_pc_c, word_c;
    logic          unused_ok_c;

    assign redir_pc_c  = {redirect_pc[31:2], 2'b00};
    assign redir_hit_c = lb_valid && (lb_tag == redirect_pc[31:4]);
    assign word_c      = lb_data[{fetch_pc[3:2], 5'd0} +: 32];
    assign q_full_c    = (q_count == 2'(QDEPTH));
    assign flush_c     = redirect_valid;
    assign pop_c       = dec_valid && dec_ready;
    assign unused_ok_c = ^redirect_pc[1:0];

    assign dec_valid = (q_count != 2'd0);
    assign dec_pc    = q_pc[0];
    assign dec_inst  = q_inst[0];

    // State, fetch PC and kill flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            kill     <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            kill     <= kill_n;
        end
    end

    // Next-state, next fetch PC, line capture and queue push decisions
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        kill_n     = kill;
        lb_load_c  = 1'b0;
        push_c     = 1'b0;
        case (state)
            IDLE: begin
                state_n = REQ;
                if (redirect_valid) begin
                    fetch_pc_n = redir_pc_c;
                    if (redir_hit_c) state_n = SERVE;
                end
            end
            REQ: begin
                // An in-flight request is never withdrawn; a redirect only marks it dead.
                if (redirect_valid) begin
                    fetch_pc_n = redir_pc_c;
                    kill_n     = 1'b1;
                end
                if (ic_ready) begin
                    lb_load_c = 1'b1;
                    state_n   = ACK;
                end
            end
            ACK: begin
                kill_n = 1'b0;
                if (redirect_valid) fetch_pc_n = redir_pc_c;
                state_n = (lb_tag == fetch_pc_n[31:4]) ? SERVE : REQ;
            end
            SERVE: begin
                if (redirect_valid) begin
                    fetch_pc_n = redir_pc_c;
                    state_n    = redir_hit_c ? SERVE : REQ;
                end else if (!q_full_c) begin
                    push_c     = 1'b1;
                    fetch_pc_n = fetch_pc + 32'd4;
                    if (fetch_pc[3:2] == 2'b11) state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered cache request and acknowledge outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_valid      <= 1'b0;
            ic_addr       <= 32'd0;
            ic_read_valid <= 1'b0;
            ic_read_clean <= 1'b0;
        end else begin
            ic_valid      <= (state_n == REQ);
            if ((state_n == REQ) && (state != REQ)) ic_addr <= {fetch_pc_n[31:4], 4'b0000};
            ic_read_valid <= (state_n == ACK) && !kill_n;
            ic_read_clean <= (state_n == ACK) && kill_n;
        end
    end

    // One-line buffer, filled on every returned line (killed or not)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_valid <= 1'b0;
            lb_tag   <= 28'd0;
            lb_data  <= 128'd0;
        end else if (lb_load_c) begin
            lb_valid <= 1'b1;
            lb_tag   <= ic_addr[31:4];
            lb_data  <= ic_data;
        end
    end

    // Two-entry decode queue; entry 0 is the head seen by decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_count   <= 2'd0;
            q_pc[0]   <= 32'd0;
            q_pc[1]   <= 32'd0;
            q_inst[0] <= 32'd0;
            q_inst[1] <= 32'd0;
        end else if (flush_c) begin
            q_count <= 2'd0;
        end else begin
            case ({push_c, pop_c})
                2'b10: begin
                    if (q_count == 2'd0) begin
                        q_pc[0]   <= fetch_pc;
                        q_inst[0] <= word_c;
                    end else begin
                        q_pc[1]   <= fetch_pc;
                        q_inst[1] <= word_c;
                    end
                    q_count <= q_count + 2'd1;
                end
                2'b01: begin
                    q_pc[0]   <= q_pc[1];
                    q_inst[0] <= q_inst[1];
                    q_count   <= q_count - 2'd1;
                end
                2'b11: begin
                    if (q_count == 2'd1) begin
                        q_pc[0]   <= fetch_pc;
                        q_inst[0] <= word_c;
                    end else begin
                        q_pc[0]   <= q_pc[1];
                        q_inst[0] <= q_inst[1];
                        q_pc[1]   <= fetch_pc;
                        q_inst[1] <= word_c;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic lb_hit_evt_c, stall_evt_c;

    assign lb_hit_evt_c = redirect_valid && redir_hit_c && ((state == IDLE) || (state == SERVE));
    assign stall_evt_c  = (state == SERVE) && q_full_c;

    // Line-buffer hit and queue-full stall counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lb_hit <= 64'd0;
            perf_stall  <= 64'd0;
        end else begin
            if (lb_hit_evt_c) perf_lb_hit <= perf_lb_hit + 64'd1;
            if (stall_evt_c)  perf_stall  <= perf_stall + 64'd1;
        end
    end
`else
    assign perf_lb_hit = 64'd0;
    assign perf_stall  = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_22041412_fetch_buffer.sv
// Directed bench for the fetch buffer with a small in-bench cache responder.
module tb_ysyx_22041412_fetch_buffer;
    logic         clk = 1'b0;
    logic         rst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         ic_valid;
    logic [31:0]  ic_addr;
    logic [127:0] ic_data;
    logic         ic_ready;
    logic         ic_read_valid;
    logic         ic_read_clean;
    logic         dec_valid;
    logic [31:0]  dec_pc;
    logic [31:0]  dec_inst;
    logic         dec_ready;
    logic [63:0]  perf_lb_hit;
    logic [63:0]  perf_stall;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc, n_rv, n_rc, wait_cnt, cache_lat;
    logic prev_icv;
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    int pop_cyc[$];
    logic [31:0] req_log[$];

    ysyx_22041412_fetch_buffer dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_data(ic_data), .ic_ready(ic_ready),
        .ic_read_valid(ic_read_valid), .ic_read_clean(ic_read_clean),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_ready(dec_ready),
        .perf_lb_hit(perf_lb_hit), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        logic [31:0] r;
        if (pc[31:4] == 28'h800_0000) begin
            case (pc[3:2])
                2'd0: r = 32'h0000_0193;
                2'd1: r = 32'h0000_0113;
                2'd2: r = 32'h0000_0093;
                default: r = 32'h0000_0013;
            endcase
        end else begin
            r = {pc[31:2], 2'b00} ^ 32'hA5A5_0000;
        end
        return r;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = exp_inst({a[31:4], 2'(k), 2'b00});
        return l;
    endfunction

    // One clock: record decode pops, then model the cache after the edge
    task automatic step();
        if (dec_valid && dec_ready) begin
            pop_pc.push_back(dec_pc);
            pop_inst.push_back(dec_inst);
            pop_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ic_read_valid) n_rv++;
        if (ic_read_clean) n_rc++;
        if (ic_valid && !prev_icv) req_log.push_back(ic_addr);
        prev_icv = ic_valid;
        if (ic_read_valid || ic_read_clean) ic_ready = 1'b0;
        if (!ic_valid) wait_cnt = 0;
        else if (!ic_ready) begin
            if (wait_cnt >= cache_lat) begin
                ic_ready = 1'b1;
                ic_data  = line_of(ic_addr);
            end else wait_cnt++;
        end
    endtask

    task automatic clear_logs();
        pop_pc.delete(); pop_inst.delete(); pop_cyc.delete(); req_log.delete();
        n_rv = 0; n_rc = 0; cyc = 0; wait_cnt = 0; prev_icv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; dec_ready = 1'b0;
        ic_ready = 1'b0; ic_data = 128'd0; cache_lat = 1;
        step(); step();
        rst = 1'b0;
        ic_ready = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; dec_ready = 1'b0;
        ic_ready = 1'b0; ic_data = 128'd0; cache_lat = 1;
        clear_logs();
        #1;
        checks++; if (ic_valid !== 1'b0) begin failures++; $display("FAIL reset_ic_valid got=%0b exp=0", ic_valid); end
        checks++; if (ic_addr !== 32'd0) begin failures++; $display("FAIL reset_ic_addr got=%h exp=0", ic_addr); end
        checks++; if ({ic_read_valid, ic_read_clean} !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", {ic_read_valid, ic_read_clean}); end
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%0b exp=0", dec_valid); end
        checks++; if ({dec_pc, dec_inst} !== 64'd0) begin failures++; $display("FAIL reset_dec got=%h exp=0", {dec_pc, dec_inst}); end
        checks++; if ({perf_lb_hit, perf_stall} !== 128'd0) begin failures++; $display("FAIL reset_perf got=%h exp=0", {perf_lb_hit, perf_stall}); end
        do_reset();
    endtask

    task automatic test_first_line();
        int t = 0;
        do_reset();
        dec_ready = 1'b1;
        while ((pop_pc.size() < 4 || req_log.size() < 2) && t < 60) begin step(); t++; end
        checks++;
        if (t >= 60) begin failures++; $display("FAIL first_line_timeout pops=%0d reqs=%0d exp>=4,>=2", pop_pc.size(), req_log.size()); end
        else begin
            if (req_log[0] !== 32'h8000_0000) begin failures++; $display("FAIL first_req got=%h exp=80000000", req_log[0]); end
            checks++;
            if (req_log[1] !== 32'h8000_0010) begin failures++; $display("FAIL second_req got=%h exp=80000010", req_log[1]); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pop_pc[i] !== 32'h8000_0000 + 32'(4 * i) || pop_inst[i] !== exp_inst(32'h8000_0000 + 32'(4 * i))) begin
                    failures++;
                    $display("FAIL first_line_word%0d got=%h/%h exp=%h/%h", i, pop_pc[i], pop_inst[i],
                             32'h8000_0000 + 32'(4 * i), exp_inst(32'h8000_0000 + 32'(4 * i)));
                end
            end
            checks++;
            if (pop_cyc[3] - pop_cyc[0] != 3) begin failures++; $display("FAIL back_to_back_span got=%0d exp=3", pop_cyc[3] - pop_cyc[0]); end
            checks++;
            if (n_rv !== 1 || n_rc !== 0) begin failures++; $display("FAIL first_ack got=rv%0d/rc%0d exp=rv1/rc0", n_rv, n_rc); end
        end
    endtask

    task automatic test_stall();
        int t = 0;
        do_reset();
        repeat (20) step();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h8000_0000) begin failures++; $display("FAIL stall_head got=%0b/%h exp=1/80000000", dec_valid, dec_pc); end
        checks++; if (req_log.size() != 1) begin failures++; $display("FAIL stall_reqs got=%0d exp=1", req_log.size()); end
        checks++; if (perf_stall !== (PERF ? 64'd14 : 64'd0)) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", perf_stall, PERF ? 14 : 0); end
        dec_ready = 1'b1;
        while (pop_pc.size() < 4 && t < 30) begin step(); t++; end
        checks++;
        if (t >= 30) begin failures++; $display("FAIL stall_drain_timeout pops=%0d exp=4", pop_pc.size()); end
        else if (pop_pc[1] !== 32'h8000_0004 || pop_pc[2] !== 32'h8000_0008 || pop_pc[3] !== 32'h8000_000C) begin
            failures++; $display("FAIL stall_drain got=%h,%h,%h exp=80000004,80000008,8000000c", pop_pc[1], pop_pc[2], pop_pc[3]);
        end
    endtask

    task automatic test_lb_hit();
        do_reset();
        repeat (6) step();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0008;
        step();
        redirect_valid = 1'b0;
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL lb_hit_flush got=%0b exp=0", dec_valid); end
        checks++; if (perf_lb_hit !== (PERF ? 64'd1 : 64'd0)) begin failures++; $display("FAIL lb_hit_count got=%0d exp=%0d", perf_lb_hit, PERF ? 1 : 0); end
        step();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h8000_0008 || dec_inst !== 32'h0000_0093) begin
            failures++; $display("FAIL lb_hit_head got=%0b/%h/%h exp=1/80000008/00000093", dec_valid, dec_pc, dec_inst); end
        checks++; if (req_log.size() != 1 || ic_valid !== 1'b0) begin failures++; $display("FAIL lb_hit_no_req got=%0d/%0b exp=1/0", req_log.size(), ic_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        dec_ready = 1'b1;
        repeat (6) step();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h8000_0004) begin failures++; $display("FAIL collide_pre got=%0b/%h exp=1/80000004", dec_valid, dec_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_000C;
        step();
        redirect_valid = 1'b0;
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL collide_flush got=%0b exp=0", dec_valid); end
        step();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h8000_000C || dec_inst !== 32'h0000_0013) begin
            failures++; $display("FAIL collide_head got=%0b/%h/%h exp=1/8000000c/00000013", dec_valid, dec_pc, dec_inst); end
    endtask

    task automatic test_kill();
        int t = 0;
        int base;
        logic moved = 1'b0;
        do_reset();
        dec_ready = 1'b1;
        cache_lat = 4;
        while (!(ic_valid && ic_addr == 32'h8000_0010) && t < 80) begin step(); t++; end
        checks++;
        if (t >= 80) begin failures++; $display("FAIL kill_reach_timeout addr=%h exp=80000010", ic_addr); return; end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1007;
        step();
        redirect_valid = 1'b0;
        base = pop_pc.size();
        if (ic_valid !== 1'b1 || ic_addr !== 32'h8000_0010) begin failures++; $display("FAIL kill_hold got=%0b/%h exp=1/80000010", ic_valid, ic_addr); end
        t = 0;
        while (n_rc == 0 && n_rv == 1 && t < 40) begin
            if (ic_valid && ic_addr !== 32'h8000_0010) moved = 1'b1;
            step(); t++;
        end
        checks++; if (moved !== 1'b0) begin failures++; $display("FAIL kill_addr_moved got=1 exp=0"); end
        checks++; if (n_rc != 1 || n_rv != 1) begin failures++; $display("FAIL kill_ack got=rv%0d/rc%0d exp=rv1/rc1", n_rv, n_rc); end
        t = 0;
        while ((req_log.size() < 3 || pop_pc.size() <= base) && t < 60) begin step(); t++; end
        checks++;
        if (t >= 60) begin failures++; $display("FAIL kill_refetch_timeout reqs=%0d exp=3", req_log.size()); end
        else begin
            if (req_log[2] !== 32'h8000_1000) begin failures++; $display("FAIL kill_new_req got=%h exp=80001000", req_log[2]); end
            checks++;
            if (pop_pc[base] !== 32'h8000_1004 || pop_inst[base] !== exp_inst(32'h8000_1004)) begin
                failures++; $display("FAIL kill_first_dec got=%h/%h exp=80001004/%h", pop_pc[base], pop_inst[base], exp_inst(32'h8000_1004)); end
        end
    endtask

    task automatic test_reset_in_req();
        int t = 0;
        do_reset();
        step();
        checks++; if (ic_valid !== 1'b1) begin failures++; $display("FAIL rreq_pre got=%0b exp=1", ic_valid); end
        rst = 1'b1;
        #1;
        checks++; if (ic_valid !== 1'b0 || ic_addr !== 32'd0) begin failures++; $display("FAIL rreq_async got=%0b/%h exp=0/0", ic_valid, ic_addr); end
        step();
        checks++; if (n_rv != 0 || n_rc != 0) begin failures++; $display("FAIL rreq_no_ack got=rv%0d/rc%0d exp=0/0", n_rv, n_rc); end
        rst = 1'b0;
        ic_ready = 1'b0;
        clear_logs();
        while (req_log.size() < 1 && t < 10) begin step(); t++; end
        checks++;
        if (t >= 10) begin failures++; $display("FAIL rreq_timeout reqs=0 exp=1"); end
        else if (req_log[0] !== 32'h8000_0000) begin failures++; $display("FAIL rreq_addr got=%h exp=80000000", req_log[0]); end
    endtask

    task automatic test_wrap();
        int t = 0;
        do_reset();
        dec_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        while ((pop_pc.size() < 2 || req_log.size() < 2) && t < 40) begin step(); t++; end
        checks++;
        if (t >= 40) begin failures++; $display("FAIL wrap_timeout pops=%0d reqs=%0d", pop_pc.size(), req_log.size()); end
        else begin
            if (req_log[0] !== 32'hFFFF_FFF0) begin failures++; $display("FAIL wrap_req0 got=%h exp=fffffff0", req_log[0]); end
            checks++;
            if (pop_pc[0] !== 32'hFFFF_FFF8 || pop_pc[1] !== 32'hFFFF_FFFC) begin
                failures++; $display("FAIL wrap_pcs got=%h,%h exp=fffffff8,fffffffc", pop_pc[0], pop_pc[1]); end
            checks++;
            if (req_log[1] !== 32'h0000_0000) begin failures++; $display("FAIL wrap_req1 got=%h exp=00000000", req_log[1]); end
            checks++;
            if (perf_lb_hit !== 64'd0) begin failures++; $display("FAIL wrap_no_hit got=%0d exp=0", perf_lb_hit); end
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_stall();
        test_lb_hit();
        test_back_to_back();
        test_kill();
        test_reset_in_req();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_22041412_fetch_buffer.md
# ysyx_22041412_fetch_buffer

Instruction fetch front end between the PC/redirect logic and the 4-way instruction cache. Owns the fetch PC, issues 16-byte line requests to the cache, and captures each returned 128-bit line into a one-line buffer. Slices 32-bit instructions out of that buffer into a 2-entry queue feeding decode. Sequential fetches and short redirects inside the buffered line are served without a new cache request.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- redirect_valid  in  1  branch/jump/trap redirect; one-cycle pulse.
- redirect_pc  in  32  new PC; bits [1:0] are ignored (treated as 0).
- ic_valid  out  1  cache request valid.
- ic_addr  out  32  request address, {fetch_pc[31:4], 4'b0}.
- ic_data  in  128  returned line; word k is at bits [32k+31:32k].
- ic_ready  in  1  line available; held by the cache until acknowledged.
- ic_read_valid  out  1  acknowledge and consume the line.
- ic_read_clean  out  1  acknowledge and discard the line (killed request).
- dec_valid  out  1  queue head valid.
- dec_pc  out  32  PC of the queue head.
- dec_inst  out  32  instruction at the queue head.
- dec_ready  in  1  decode accepts the head.
- perf_lb_hit  out  64  line-buffer hit count (see Configuration).
- perf_stall  out  64  queue-full stall cycle count (see Configuration).

## Operation
- Internal state: fetch_pc; line buffer {lb_valid, lb_tag[31:4], lb_data[127:0]}; 2-entry FIFO of {pc, inst}; kill flag.
- FSM states: IDLE, REQ, ACK, SERVE.
  - IDLE: entered after reset; moves to REQ next cycle.
  - REQ: ic_valid=1, ic_addr holds its value while in REQ.
    - On ic_ready: capture ic_data into lb_data, set lb_tag = ic_addr[31:4] and lb_valid=1, go to ACK.
    - The line is captured even when kill=1; the data is correct for its address.
  - ACK: ic_valid=0 for exactly one cycle.
    - Pulse ic_read_clean if kill=1, else pulse ic_read_valid. Clear kill.
    - Go to SERVE if lb_tag==fetch_pc[31:4], else go to REQ.
  - SERVE: each cycle the FIFO is not full, push {fetch_pc, lb_data word fetch_pc[3:2]} and set fetch_pc += 4.
    - If the pushed word was word 3, go to REQ for the next line.
- Redirect, any state: set fetch_pc = {redirect_pc[31:2], 2'b00} and flush the FIFO (count=0).
  - In REQ: stay in REQ with the old ic_addr and set kill=1. A cache request is never withdrawn mid-flight.
  - In SERVE or IDLE: if lb_valid and lb_tag==redirect_pc[31:4], go to SERVE (line-buffer hit); otherwise go to REQ.
  - In ACK: the ACK actions still complete. The next-state check then uses the new fetch_pc.
- Simultaneous redirect and SERVE push: redirect wins and no push occurs that cycle.
- FIFO: push is allowed only when the registered count < 2. Pop happens on dec_valid & dec_ready. A pop and a push may occur in the same cycle.
- fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no special handling.

## Timing
- Reset values: FSM state IDLE, fetch_pc=RESET_PC, lb_valid=0, kill=0, FIFO empty. Outputs: ic_valid=0, ic_addr=0, ic_read_valid=0, ic_read_clean=0, dec_valid=0, dec_pc=0, dec_inst=0, perf_*=0.
- All outputs are registered, except dec_* which come directly from the FIFO head register.
- Cache handshake: capture happens in the first cycle ic_ready=1 while in REQ. The acknowledge pulse follows one cycle later. ic_valid is low for at least that one cycle before the next request.
- Line-buffer hit after a redirect: first push in the next cycle; dec_valid two cycles after redirect_valid.
- Steady state with dec_ready=1: one instruction per cycle for the 4 words of a line, then a refetch.
- Reset mid-operation clears all state immediately, including kill. No acknowledge is issued. The cache is reset in the same domain.

## Configuration
- FETCH_PERF_EN defined:
  - perf_lb_hit increments on every redirect served from the line buffer.
  - perf_stall increments on every SERVE cycle with the FIFO full.
- FETCH_PERF_EN undefined: both counters are removed and perf_lb_hit and perf_stall are tied to 0.

## Test plan
- Reset, cache returns line 128'h…_00000013_00000093_00000113_00000193 at 0x8000_0000 -> ic_addr=0x8000_0000, ic_read_valid pulses once, decode sees PCs 0x8000_0000/04/08/0C with insts 0x193,0x113,0x93,0x13, then ic_addr=0x8000_0010.
- dec_ready held 0 -> exactly 2 entries are queued, fetch_pc stops at +8, and perf_stall counts each blocked cycle (FETCH_PERF_EN).
- Redirect to 0x8000_0008 while in SERVE on line 0x8000_0000 -> no cache request, next dec_pc=0x8000_0008, perf_lb_hit=1.
- Redirect to 0x8000_1004 while in REQ for 0x8000_0010 -> ic_addr stays 0x8000_0010 until ic_ready, ic_read_clean pulses (not ic_read_valid), the next request is 0x8000_1000, and the first dec_pc=0x8000_1004.
- Redirect in the same cycle as a SERVE push -> FIFO is empty the next cycle and no stale PC reaches decode.
- Assert rst during REQ -> ic_valid=0 immediately and the next request is at RESET_PC.
